cint_rst_sequencer: RTL
=======================

# cint_rst_sequencer

Executes the restart/CINT0 call that the instruction decoder has already identified. It consumes the decoder's `enable_cint` strobe and the seven one-hot restart-vector low-byte selects, and pushes the current PC onto the stack as two byte writes, high byte first. It then loads PC with the restart vector and SP with SP−2. It sits directly downstream of the RST decoder, between it and the register file / memory write port.

## Interface
Parameters:
- `ADDR_W`, 16, PC/SP/memory address width.
- `DATA_W`, 8, memory data width; must equal `ADDR_W/2`.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `enable_cint`  in  1  start strobe from the decoder; sampled only in IDLE.
- `PA_Select_0x8_low` … `PA_Select_0x38_low`  in  1 each (7)  one-hot vector selects; none asserted means vector 0x00.
- `pc_in`  in  ADDR_W  current PC, i.e. the return address.
- `sp_in`  in  ADDR_W  current SP.
- `mem_wr_req`  out  1  write request.
- `mem_wr_addr`  out  ADDR_W  write address.
- `mem_wr_data`  out  DATA_W  write data.
- `mem_wr_ack`  in  1  write accepted; may arrive in the same cycle as `mem_wr_req`.
- `pc_load`  out  1  one-cycle strobe: PC ← `pc_out`.
- `pc_out`  out  ADDR_W  new PC, {8'h00, vector}.
- `sp_load`  out  1  one-cycle strobe, coincident with `pc_load`: SP ← `sp_out`.
- `sp_out`  out  ADDR_W  `sp_in` latched at start, minus 2.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse, high in the cycle after `pc_load`.

## Operation
- States: IDLE, PUSH_HI, PUSH_LO, LOAD, DONE.
- IDLE, with `enable_cint`=1:
  - Latch `pc_in`, `sp_in` and the encoded vector.
  - Go to PUSH_HI.
- IDLE, with `enable_cint`=0: stay in IDLE.
- Vector encoding:
  - Select k (k=1..7) gives vector low byte k×8 (0x08..0x38).
  - No select asserted gives 0x00.
  - More than one select asserted: the highest k wins. This is defined behaviour, not an error.
- PUSH_HI:
  - `mem_wr_req`=1, `mem_wr_addr`=SP−1, `mem_wr_data`=PC[15:8].
  - Hold until `mem_wr_ack`, then go to PUSH_LO.
- PUSH_LO:
  - `mem_wr_req`=1, `mem_wr_addr`=SP−2, `mem_wr_data`=PC[7:0].
  - On `mem_wr_ack`, go to LOAD.
- LOAD: `pc_load`=`sp_load`=1 for exactly one cycle, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Arithmetic: modulo 2^ADDR_W. SP=0x0000 writes 0xFFFF, then 0xFFFE; `sp_out`=0xFFFE. SP=0x0001 writes 0x0000, then 0xFFFF.
- `enable_cint` while `busy` is ignored and is not queued.
- `mem_wr_ack` while `mem_wr_req`=0 is ignored.
- Latched PC, SP and vector are immune to input changes after start.

## Timing
- Reset values:
  - State IDLE.
  - `mem_wr_req`, `pc_load`, `sp_load`, `busy`, `done` = 0.
  - `mem_wr_addr`, `mem_wr_data`, `pc_out`, `sp_out` = 0.
- `rst` mid-operation: next cycle is IDLE with all reset values. No PC/SP load occurs; any half-completed push is abandoned.
- `mem_wr_req` is registered. Address and data stay stable while req=1 and ack=0.
- With ack in the same cycle as req, cycles measured from the start edge:
  - PUSH_HI: cycle 1.
  - PUSH_LO: cycle 2.
  - LOAD (`pc_load`): cycle 3.
  - `done`: cycle 4.
  - IDLE: cycle 5.
- Each wait cycle with ack low adds one cycle per push.
- Start to next accepted start: minimum 5 cycles.
- All outputs are driven from registers or the state register; there is no combinational path from input to output.

## Structure
- Shared package `cint_pkg`:
  - State enum.
  - `CINT_VEC_STEP`=8.
  - `ADDR_W`/`DATA_W` defaults.
  - Vector width constant (8).
- Sub-module `cint_vector_encoder`: combinational 7-bit one-hot to 8-bit vector, highest-k priority. Instantiated once.
- The main module holds the FSM, latches, and SP−1/SP−2 subtractors.

## Test plan
- PC=0x1234, SP=0xFF00, select 0x28, ack same cycle → writes (0xFEFF, 0x12), (0xFEFE, 0x34); `pc_out`=0x0028, `sp_out`=0xFEFE; `done` at cycle 4.
- No select asserted, PC=0xABCD, SP=0x0000 → writes (0xFFFF, 0xAB), (0xFFFE, 0xCD); `pc_out`=0x0000, `sp_out`=0xFFFE.
- Ack delayed 3 cycles on each push → req, addr and data held steady throughout; `pc_load` at cycle 9; exactly two writes.
- Selects 0x10 and 0x38 both asserted → `pc_out`=0x0038.
- `enable_cint` pulsed during PUSH_LO, and PC/SP changed after start → ignored; outputs use the latched values; a single `done`.
- `rst` asserted in PUSH_LO → next cycle all outputs 0, no `pc_load`; a fresh start then completes normally.

Source files
------------

// File: rtl/cint_pkg.sv
// Shared types and constants for the restart/CINT0 call sequencer.
// Holds the FSM state encoding, default bus widths and restart-vector geometry.
// Imported by the sequencer and its vector encoder.
package cint_pkg;

  // Default widths: PC/SP/address bus and the byte-wide memory data bus.
  localparam int CINT_ADDR_W   = 16;
  localparam int CINT_DATA_W   = 8;

  // Restart vectors are multiples of 8 in the low byte of page zero.
  localparam int CINT_VEC_STEP = 8;
  localparam int CINT_VEC_W    = 8;
  localparam int CINT_NUM_SEL  = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUSH_HI = 3'd1,
    ST_PUSH_LO = 3'd2,
    ST_LOAD    = 3'd3,
    ST_DONE    = 3'd4
  } cint_state_t;

endpackage

// File: rtl/cint_vector_encoder.sv
// Purpose: turns the seven restart-vector selects into the vector low byte.
// Latency: purely combinational; several selects set -> highest index wins.
// Backpressure: none, it is a pure function of its input.
module cint_vector_encoder
  import cint_pkg::*;
(
  input  logic [CINT_NUM_SEL-1:0] sel,
  output logic [CINT_VEC_W-1:0]   vec
);

  // Ascending scan: a later (higher) select overrides any lower one.
  always_comb begin
    vec = '0;
    for (int k = 0; k < CINT_NUM_SEL; k++) begin
      if (sel[k]) begin
        vec = CINT_VEC_W'((k + 1) * CINT_VEC_STEP);
      end
    end
  end

endmodule

// File: rtl/cint_rst_sequencer.sv
// Purpose: executes a decoded restart call: pushes PC (high byte first), then loads PC/SP.
// Latency: start -> pc_load in 3 cycles with immediate acks, +1 per ack wait cycle; done one cycle later.
// Backpressure: each push holds req/addr/data until mem_wr_ack; enable_cint while busy is dropped.
module cint_rst_sequencer
  import cint_pkg::*;
#(
  parameter int ADDR_W = CINT_ADDR_W,
  parameter int DATA_W = CINT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_cint,
  input  logic              PA_Select_0x8_low,
  input  logic              PA_Select_0x10_low,
  input  logic              PA_Select_0x18_low,
  input  logic              PA_Select_0x20_low,
  input  logic              PA_Select_0x28_low,
  input  logic              PA_Select_0x30_low,
  input  logic              PA_Select_0x38_low,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] sp_in,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_ack,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_out,
  output logic              sp_load,
  output logic [ADDR_W-1:0] sp_out,
  output logic              busy,
  output logic              done
);

  cint_state_t state, state_nxt;

  logic [CINT_NUM_SEL-1:0] sel;
  logic [CINT_VEC_W-1:0]   vec;
  logic                    start;

  // Only the low PC byte must survive past the start edge; the high byte is
  // written into mem_wr_data on the start edge itself.
  logic [DATA_W-1:0]       pc_lo_lat;

  logic [ADDR_W-1:0]       sp_in_m1;
  logic [ADDR_W-1:0]       sp_in_m2;

  logic                    mem_wr_req_nxt;
  logic [ADDR_W-1:0]       mem_wr_addr_nxt;
  logic [DATA_W-1:0]       mem_wr_data_nxt;
  logic                    pc_load_nxt;
  logic                    sp_load_nxt;
  logic [ADDR_W-1:0]       pc_out_nxt;
  logic [ADDR_W-1:0]       sp_out_nxt;
  logic                    busy_nxt;
  logic                    done_nxt;

  assign sel = {PA_Select_0x38_low, PA_Select_0x30_low, PA_Select_0x28_low,
                PA_Select_0x20_low, PA_Select_0x18_low, PA_Select_0x10_low,
                PA_Select_0x8_low};

  cint_vector_encoder u_vec_enc (
    .sel (sel),
    .vec (vec)
  );

  // Stack grows downward and wraps modulo 2^ADDR_W.
  assign sp_in_m1 = sp_in - ADDR_W'(1);
  assign sp_in_m2 = sp_in - ADDR_W'(2);
  assign start    = (state == ST_IDLE) && enable_cint;

  // State register plus registered outputs, so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      mem_wr_req  <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      pc_load     <= 1'b0;
      sp_load     <= 1'b0;
      pc_out      <= '0;
      sp_out      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      mem_wr_req  <= mem_wr_req_nxt;
      mem_wr_addr <= mem_wr_addr_nxt;
      mem_wr_data <= mem_wr_data_nxt;
      pc_load     <= pc_load_nxt;
      sp_load     <= sp_load_nxt;
      pc_out      <= pc_out_nxt;
      sp_out      <= sp_out_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

  // Capture the return address low byte at start; later PC changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_lo_lat <= '0;
    end else if (start) begin
      pc_lo_lat <= pc_in[DATA_W-1:0];
    end
  end

  // Next-state and next-output decode. pc_out/sp_out are loaded at start and
  // double as the latched vector and SP-2 for the rest of the call.
  always_comb begin
    state_nxt       = state;
    mem_wr_req_nxt  = 1'b0;
    mem_wr_addr_nxt = '0;
    mem_wr_data_nxt = '0;
    pc_load_nxt     = 1'b0;
    sp_load_nxt     = 1'b0;
    pc_out_nxt      = pc_out;
    sp_out_nxt      = sp_out;
    busy_nxt        = 1'b1;
    done_nxt        = 1'b0;

    case (state)
      ST_IDLE: begin
        busy_nxt = 1'b0;
        if (enable_cint) begin
          state_nxt       = ST_PUSH_HI;
          busy_nxt        = 1'b1;
          mem_wr_req_nxt  = 1'b1;
          mem_wr_addr_nxt = sp_in_m1;
          mem_wr_data_nxt = pc_in[ADDR_W-1:DATA_W];
          pc_out_nxt      = {{(ADDR_W-CINT_VEC_W){1'b0}}, vec};
          sp_out_nxt      = sp_in_m2;
        end
      end
      ST_PUSH_HI: begin
        mem_wr_req_nxt = 1'b1;
        if (mem_wr_ack) begin
          state_nxt       = ST_PUSH_LO;
          mem_wr_addr_nxt = sp_out;
          mem_wr_data_nxt = pc_lo_lat;
        end else begin
          mem_wr_addr_nxt = mem_wr_addr;
          mem_wr_data_nxt = mem_wr_data;
        end
      end
      ST_PUSH_LO: begin
        if (mem_wr_ack) begin
          state_nxt   = ST_LOAD;
          pc_load_nxt = 1'b1;
          sp_load_nxt = 1'b1;
        end else begin
          mem_wr_req_nxt  = 1'b1;
          mem_wr_addr_nxt = mem_wr_addr;
          mem_wr_data_nxt = mem_wr_data;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_DONE;
        done_nxt  = 1'b1;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = ST_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
